// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and default-slave state encoding used by the
// address decoder and its default slave.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] ds_state_t;

    localparam ds_state_t ST_IDLE = 2'd0;
    localparam ds_state_t ST_ERR1 = 2'd1;
    localparam ds_state_t ST_ERR2 = 2'd2;

    // Data-phase select bit positions, {def,x2,x1}.
    localparam int unsigned DSEL_X1  = 0;
    localparam int unsigned DSEL_X2  = 1;
    localparam int unsigned DSEL_DEF = 2;

    localparam logic [2:0] DSEL_RESET = 3'b100;

    // True for transfer types that demand a data phase (NONSEQ/SEQ).
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_decoder_if.sv
// Request-side decoder bus bundle: address-phase inputs plus the selects,
// data-phase steering and default-slave response it produces.
interface ahb_lite_decoder_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned ERRCNT_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HREADY;
    logic                    ERR_CLR;
    logic                    HSELx1;
    logic                    HSELx2;
    logic                    HSELdef;
    logic [2:0]              DSEL;
    logic                    HREADYOUTdef;
    logic                    HRESPdef;
    logic [ERRCNT_WIDTH-1:0] ERR_COUNT;

    modport master (
        output HADDR, HTRANS, HREADY, ERR_CLR,
        input  HSELx1, HSELx2, HSELdef, DSEL, HREADYOUTdef, HRESPdef, ERR_COUNT
    );

    modport slave (
        input  HADDR, HTRANS, HREADY, ERR_CLR,
        output HSELx1, HSELx2, HSELdef, DSEL, HREADYOUTdef, HRESPdef, ERR_COUNT
    );
endinterface

// File: rtl/ahb_lite_decoder_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR response per accepted
// transfer, plus a saturating count of ERROR responses for debug.
module ahb_default_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    act,
    input  logic                    err_clr,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [ERRCNT_WIDTH-1:0] err_count
);

    ds_state_t               state_q, state_d;
    logic [ERRCNT_WIDTH-1:0] count_q, count_d;
    logic                    err_entry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (act) state_d = ST_ERR1;
            // The master cannot withdraw a transfer already accepted.
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = act ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ERR1 is only ever entered, never held, so this marks each new error.
    assign err_entry = (state_d == ST_ERR1);

    always_comb begin
        count_d = count_q;
        if (err_clr) begin
            count_d = err_entry ? ERRCNT_WIDTH'(1) : '0;
        end else if (err_entry && (count_q != '1)) begin
            count_d = count_q + ERRCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        hreadyout = (state_q != ST_ERR1);
        hresp     = (state_q == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
        err_count = count_q;
    end

endmodule

// File: rtl/ahb_lite_decoder.sv
// AHB-Lite address decoder: combinational slave selects, registered data-phase
// select for the response mux, and the embedded default slave.
module ahb_lite_decoder
    import ahb_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_MASK     = 32'hFFFF_F000,
    parameter logic [ADDR_WIDTH-1:0] AES_BASE     = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] AES_MASK     = 32'hFFFF_FF00,
    parameter int unsigned           ERRCNT_WIDTH = 8
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_lite_decoder_if.slave bus
);

    logic       mem_hit;
    logic       aes_hit;
    logic       sel_x1;
    logic       sel_x2;
    logic       sel_def;
    logic       act;
    logic [2:0] dsel_q, dsel_d;

    assign mem_hit = ((bus.HADDR & MEM_MASK) == MEM_BASE);
    assign aes_hit = ((bus.HADDR & AES_MASK) == AES_BASE);

    // Memory wins any overlap so the selects stay mutually exclusive.
    assign sel_x1  = mem_hit;
    assign sel_x2  = aes_hit & ~mem_hit;
    assign sel_def = ~sel_x1 & ~sel_x2;

    assign act = sel_def & htrans_active(bus.HTRANS) & bus.HREADY;

    always_comb begin
        dsel_d = dsel_q;
        if (bus.HREADY) begin
            dsel_d           = '0;
            dsel_d[DSEL_X1]  = sel_x1;
            dsel_d[DSEL_X2]  = sel_x2;
            dsel_d[DSEL_DEF] = sel_def;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= DSEL_RESET;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    assign bus.HSELx1  = sel_x1;
    assign bus.HSELx2  = sel_x2;
    assign bus.HSELdef = sel_def;
    assign bus.DSEL    = dsel_q;

    ahb_default_slave #(
        .ERRCNT_WIDTH (ERRCNT_WIDTH)
    ) u_default_slave (
        .clk       (HCLK),
        .rst       (HRESET),
        .act       (act),
        .err_clr   (bus.ERR_CLR),
        .hreadyout (bus.HREADYOUTdef),
        .hresp     (bus.HRESPdef),
        .err_count (bus.ERR_COUNT)
    );

    dsel_onehot_a: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(dsel_q));

endmodule

// File: tb/tb_ahb_lite_decoder.sv
// Directed bench for ahb_lite_decoder: table-driven decode/DSEL vectors plus
// hand-written default-slave error, saturation, clear and reset sequences.
module tb_ahb_lite_decoder;
    import ahb_lite_pkg::*;

    logic HCLK;
    logic HRESET;
    int   tests;
    int   fails;

    ahb_lite_decoder_if #(.ADDR_WIDTH(32), .ERRCNT_WIDTH(8)) bus ();

    ahb_lite_decoder dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hready;
        logic        x1;
        logic        x2;
        logic        def;
        logic [2:0]  dsel;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
        bus.HADDR  = a;
        bus.HTRANS = t;
        bus.HREADY = r;
    endtask

    task automatic check_ds(input string name, input logic rdy, input logic rsp,
                            input logic [7:0] cnt);
        check({name, " hreadyout"}, 32'(bus.HREADYOUTdef), 32'(rdy));
        check({name, " hresp"}, 32'(bus.HRESPdef), 32'(rsp));
        check({name, " err_count"}, 32'(bus.ERR_COUNT), 32'(cnt));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{32'h0000_0010, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001};
        vecs[1] = '{32'h4000_0004, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[2] = '{32'h0000_0FFC, HTRANS_SEQ,    1'b1, 1'b1, 1'b0, 1'b0, 3'b001};
        vecs[3] = '{32'h0000_1000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[4] = '{32'h4000_00FF, HTRANS_IDLE,   1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[5] = '{32'h4000_0100, HTRANS_BUSY,   1'b1, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[6] = '{32'h0000_0004, HTRANS_NONSEQ, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[7] = '{32'h4000_0000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100};
        vecs[8] = '{32'h4000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};

        HRESET      = 1'b1;
        bus.ERR_CLR = 1'b0;
        drive(32'h0, HTRANS_IDLE, 1'b1);
        step();
        step();
        check("reset dsel", 32'(bus.DSEL), 32'h4);
        check_ds("reset", 1'b1, 1'b0, 8'd0);
        HRESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].haddr, vecs[i].htrans, vecs[i].hready);
            #1;
            check($sformatf("vec%0d hselx1", i), 32'(bus.HSELx1), 32'(vecs[i].x1));
            check($sformatf("vec%0d hselx2", i), 32'(bus.HSELx2), 32'(vecs[i].x2));
            check($sformatf("vec%0d hseldef", i), 32'(bus.HSELdef), 32'(vecs[i].def));
            step();
            check($sformatf("vec%0d dsel", i), 32'(bus.DSEL), 32'(vecs[i].dsel));
            check_ds($sformatf("vec%0d", i), 1'b1, 1'b0, 8'd0);
        end

        // Single error; master drops to IDLE during the wait cycle.
        drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1);
        step();
        check_ds("single err1", 1'b0, 1'b1, 8'd1);
        check("single dsel", 32'(bus.DSEL), 32'h4);
        drive(32'h8000_0000, HTRANS_IDLE, 1'b0);
        step();
        check_ds("single err2", 1'b1, 1'b1, 8'd1);
        drive(32'h8000_0000, HTRANS_IDLE, 1'b1);
        step();
        check_ds("single idle", 1'b1, 1'b0, 8'd1);

        // Back-to-back errors, second accepted during ERR2.
        drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1);
        step();
        check_ds("b2b err1a", 1'b0, 1'b1, 8'd2);
        bus.HREADY = 1'b0;
        step();
        check_ds("b2b err2a", 1'b1, 1'b1, 8'd2);
        bus.HREADY = 1'b1;
        step();
        check_ds("b2b err1b", 1'b0, 1'b1, 8'd3);
        bus.HREADY = 1'b0;
        step();
        check_ds("b2b err2b", 1'b1, 1'b1, 8'd3);
        drive(32'h8000_0000, HTRANS_IDLE, 1'b1);
        step();
        check_ds("b2b idle", 1'b1, 1'b0, 8'd3);

        // An active request seen in ERR1 must not restart the error.
        drive(32'hC000_0000, HTRANS_SEQ, 1'b1);
        step();
        check_ds("err1 hold err1", 1'b0, 1'b1, 8'd4);
        step();
        check_ds("err1 hold err2", 1'b1, 1'b1, 8'd4);
        drive(32'hC000_0000, HTRANS_IDLE, 1'b1);
        step();
        check_ds("err1 hold idle", 1'b1, 1'b0, 8'd4);

        // Continuous errors: one entry every two cycles, 251 entries -> 255.
        drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1);
        repeat (501) step();
        check_ds("sat reach", 1'b0, 1'b1, 8'd255);
        step();
        check_ds("sat err2", 1'b1, 1'b1, 8'd255);
        step();
        check_ds("sat hold", 1'b0, 1'b1, 8'd255);
        step();
        bus.ERR_CLR = 1'b1;
        step();
        check_ds("clr with entry", 1'b0, 1'b1, 8'd1);
        bus.HTRANS = HTRANS_IDLE;
        step();
        check_ds("clr alone", 1'b1, 1'b1, 8'd0);
        bus.ERR_CLR = 1'b0;
        step();
        check_ds("clr idle", 1'b1, 1'b0, 8'd0);

        // Reset during ERR1 returns straight to IDLE.
        drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1);
        step();
        check_ds("rst pre err1", 1'b0, 1'b1, 8'd1);
        HRESET = 1'b1;
        step();
        check_ds("rst mid err", 1'b1, 1'b0, 8'd0);
        check("rst mid dsel", 32'(bus.DSEL), 32'h4);
        HRESET = 1'b0;
        drive(32'h8000_0000, HTRANS_IDLE, 1'b1);
        step();
        check_ds("rst after", 1'b1, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
